// File: rtl/sad_y16.sv
// Row-serial sum-of-absolute-differences cost for a 16x16 luma block.
// Captures pred/src on start, folds one row per cycle, then pulses done with the final score.
module sad_y16 #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 16,
    parameter int SAD_WIDTH  = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] src,
    output logic [SAD_WIDTH-1:0]                       sad,
    output logic                                       done,
    output logic                                       busy
);

    localparam int BLK_BITS = BIT_WIDTH * BLOCK_SIZE * BLOCK_SIZE;
    localparam int ROW_BITS = BIT_WIDTH * BLOCK_SIZE;
    localparam int ROW_W    = $clog2(BLOCK_SIZE);
    localparam int RS_W     = BIT_WIDTH + ROW_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [SAD_WIDTH-1:0]   acc_q, acc_d;
    logic [SAD_WIDTH-1:0]   sad_q, sad_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [BLK_BITS-1:0]    pred_q, pred_d;
    logic [BLK_BITS-1:0]    src_q, src_d;

    logic [ROW_BITS-1:0]    pred_rows [BLOCK_SIZE];
    logic [ROW_BITS-1:0]    src_rows  [BLOCK_SIZE];
    logic [ROW_BITS-1:0]    pred_row;
    logic [ROW_BITS-1:0]    src_row;
    logic [BIT_WIDTH-1:0]   abs_diff [BLOCK_SIZE];
    logic [RS_W-1:0]        rowsum;
    logic [SAD_WIDTH-1:0]   acc_sum;
    logic                   row_last;

    // Split the captured blocks into rows so the current row is a plain array select.
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_rows
        assign pred_rows[gi] = pred_q[gi*ROW_BITS +: ROW_BITS];
        assign src_rows[gi]  = src_q[gi*ROW_BITS +: ROW_BITS];
    end

    assign pred_row = pred_rows[row_q];
    assign src_row  = src_rows[row_q];

    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_abs
        logic [BIT_WIDTH-1:0] s_px;
        logic [BIT_WIDTH-1:0] p_px;
        assign s_px = src_row[gi*BIT_WIDTH +: BIT_WIDTH];
        assign p_px = pred_row[gi*BIT_WIDTH +: BIT_WIDTH];
        assign abs_diff[gi] = (s_px >= p_px) ? (s_px - p_px) : (p_px - s_px);
    end

    always_comb begin
        rowsum = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rowsum = rowsum + RS_W'(abs_diff[i]);
        end
    end

    assign acc_sum  = acc_q + SAD_WIDTH'(rowsum);
    assign row_last = (row_q == ROW_W'(BLOCK_SIZE - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        acc_d   = acc_q;
        sad_d   = sad_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        pred_d  = pred_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pred_d  = pred;
                    src_d   = src;
                    acc_d   = '0;
                    row_d   = '0;
                    state_d = S_ACC;
                    busy_d  = 1'b1;
                end
            end
            S_ACC: begin
                busy_d = 1'b1;
                if (row_last) begin
                    // sad is left untouched until this point so it always reflects a finished block.
                    sad_d   = acc_sum;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_sum;
                    row_d = row_q + ROW_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            acc_q   <= '0;
            sad_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pred_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            sad_q   <= sad_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pred_q  <= pred_d;
            src_q   <= src_d;
        end
    end

    assign sad  = sad_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sad_y16.sv
// Self-checking bench for sad_y16: directed corner blocks plus random blocks
// compared against a pixel-array SAD model.
module tb_sad_y16;

    localparam int NPIX = 256;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2047:0]     pred;
    logic [2047:0]     src;
    logic [15:0]       sad;
    logic              done;
    logic              busy;

    int n_checks;
    int n_fail;
    int pa [NPIX];
    int sa [NPIX];
    int prev_sad;

    sad_y16 #(.BIT_WIDTH(8), .BLOCK_SIZE(16), .SAD_WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pred  (pred),
        .src   (src),
        .sad   (sad),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int model_sad();
        int t;
        t = 0;
        for (int i = 0; i < NPIX; i++) begin
            t += (sa[i] > pa[i]) ? (sa[i] - pa[i]) : (pa[i] - sa[i]);
        end
        return t;
    endfunction

    task automatic fill(input int pv, input int sv);
        for (int i = 0; i < NPIX; i++) begin
            pa[i] = pv;
            sa[i] = sv;
        end
    endtask

    task automatic fill_random(input int max_delta);
        for (int i = 0; i < NPIX; i++) begin
            pa[i] = $urandom_range(255, 0);
            if (max_delta >= 255) begin
                sa[i] = $urandom_range(255, 0);
            end else begin
                sa[i] = pa[i] + $urandom_range(2 * max_delta, 0) - max_delta;
                if (sa[i] < 0)   sa[i] = 0;
                if (sa[i] > 255) sa[i] = 255;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NPIX; i++) begin
            pred[8*i +: 8] = pa[i][7:0];
            src[8*i +: 8]  = sa[i][7:0];
        end
    endtask

    // One block transaction. disturb: re-pulse start while busy and scramble inputs after capture.
    // abort: pulse rst during the block and expect everything back at reset values.
    task automatic run_block(input string tag, input bit disturb, input bit abort);
        int exp_sad;
        int n_done;
        exp_sad = model_sad();
        n_done  = 0;
        @(negedge clk);
        drive_inputs();
        start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (abort && k == 9) begin
                rst = 1'b1;
                #1;
                check({tag, " abort busy"}, int'(busy), 0);
                check({tag, " abort done"}, int'(done), 0);
                check({tag, " abort sad"}, int'(sad), 0);
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < 18; j++) begin
                    @(negedge clk);
                    if (done) n_done++;
                end
                check({tag, " abort no done pulse"}, n_done, 0);
                check({tag, " abort idle busy"}, int'(busy), 0);
                prev_sad = 0;
                $display("txn %s: aborted, sad=%0d", tag, sad);
                return;
            end
            if (done) n_done++;
            check($sformatf("%s busy k=%0d", tag, k), int'(busy), (k <= 17) ? 1 : 0);
            check($sformatf("%s done k=%0d", tag, k), int'(done), (k == 17) ? 1 : 0);
            if (k == 17) check({tag, " sad"}, int'(sad), exp_sad);
            else if (k < 17) check($sformatf("%s sad hold k=%0d", tag, k), int'(sad), prev_sad);
            if (disturb) begin
                if (k == 5) begin
                    start = 1'b1;
                    pred  = {64{$urandom()}};
                    src   = {64{$urandom()}};
                end
                if (k == 6)  start = 1'b0;
                if (k == 17) start = 1'b1;
                if (k == 18) start = 1'b0;
            end
        end
        check({tag, " done count"}, n_done, 1);
        prev_sad = exp_sad;
        $display("txn %s: sad=%0d expected=%0d", tag, sad, exp_sad);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_sad = 0;
        rst      = 1'b1;
        start    = 1'b0;
        pred     = '0;
        src      = '0;
        repeat (3) @(negedge clk);
        check("reset sad", int'(sad), 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        fill(8'h80, 8'h80);
        run_block("equal_0x80", 1'b0, 1'b0);

        fill(8'h80, 8'hFF);
        run_block("src_ff_pred_80", 1'b0, 1'b0);

        fill(8'hFF, 8'h00);
        run_block("pred_ff_src_00", 1'b0, 1'b0);

        fill(8'h00, 8'hFF);
        run_block("pred_00_src_ff", 1'b0, 1'b0);

        fill(8'h55, 8'h55);
        sa[3*16+5]  = 8'h10;
        pa[3*16+5]  = 8'h20;
        sa[15*16+15] = 8'hF0;
        pa[15*16+15] = 8'h00;
        run_block("two_pixel", 1'b0, 1'b0);

        fill_random(255);
        run_block("disturbed", 1'b1, 1'b0);

        fill_random(255);
        run_block("abort", 1'b0, 1'b1);

        fill_random(255);
        run_block("after_abort", 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill_random((t % 2 == 0) ? 255 : 12);
            run_block($sformatf("random%0d", t), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_y16.md
Name: sad_y16

Overview:
- Cost stage directly downstream of the 16x16 luma DC predictor.
- Consumes the packed predicted block and the matching source block.
- Accumulates the sum of absolute differences (SAD) one row per cycle and reports a single score with a done pulse.
- Mode decision logic uses the score to compare intra-prediction candidates.

Parameters:
- BIT_WIDTH, 8, bits per pixel.
- BLOCK_SIZE, 16, block width and height in pixels; must be 16.
- SAD_WIDTH, 16, width of the SAD result; must be at least BIT_WIDTH + 2*log2(BLOCK_SIZE).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- pred  input  BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE  predicted block, packed.
- src  input  BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE  source block, packed, same layout as pred.
- sad  output  SAD_WIDTH  SAD of the last completed block.
- done  output  1  one-cycle pulse; sad is valid and updated in the same cycle.
- busy  output  1  high while a block is being processed.

Behaviour:
- Reset (rst=1, asynchronous): state IDLE, sad=0, done=0, busy=0, row counter=0, accumulator=0, capture registers=0.
- Packing: pixel (r,c) occupies bits [BIT_WIDTH*(BLOCK_SIZE*r+c) +: BIT_WIDTH] of pred and of src. Row r is a contiguous 128-bit slice.
- States:
  - IDLE: busy=0. If start=1, capture pred and src into internal registers, clear accumulator, set row=0, go to ACC. If start=0, stay in IDLE.
  - ACC: busy=1. Each cycle compute rowsum = sum over c of |src(row,c) - pred(row,c)|.
    - Each difference is evaluated unsigned and never wraps (absolute value of the true difference).
    - rowsum needs BIT_WIDTH+4 bits.
    - If row < BLOCK_SIZE-1: acc <= acc + rowsum, row <= row+1.
    - If row = BLOCK_SIZE-1: sad <= acc + rowsum, done <= 1, go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle. Next edge: done <= 0, go to IDLE.
- Latency: start sampled high at edge N. ACC occupies cycles N+1..N+16. done=1 and the new sad are visible during cycle N+17. IDLE resumes at N+18. Throughput is one block per 18 cycles.
- Inputs are captured at start. pred and src may change freely after the start edge without affecting the result.
- start while busy (ACC or DONE): ignored, not queued. A start in the DONE cycle is also ignored; the requester must re-assert in IDLE.
- sad holds its value until the next completed block. It is not cleared when a new start is accepted.
- Arithmetic: no saturation is needed. The maximum 255*256 = 65280 fits in 16 bits, and the accumulator is SAD_WIDTH bits wide.
- Reset mid-operation: abort immediately to reset values. No done pulse is produced for the aborted block.
- Output timing: done, busy and sad are registered outputs with no combinational path from inputs.

Test Plan:
1. Reset, then start with pred=src=all 0x80 -> done high exactly at cycle N+17 with sad=0; busy high for N+1..N+17.
2. pred all 0x80 (DC predictor "none" fill), src all 0xFF -> sad=32512 (127*256).
3. pred all 0xFF, src all 0x00 -> sad=65280; then swap the two inputs -> sad=65280, which checks that the absolute value is symmetric.
4. pred=src except pixel (3,5): src=0x10, pred=0x20; and pixel (15,15): src=0xF0, pred=0x00 -> sad=16+240=256, which checks row packing and the last-row accumulate.
5. start re-pulsed at N+5 and again during the DONE cycle, and pred changed after N -> exactly one done pulse, and sad reflects the data captured at N.
6. Assert rst at cycle N+9 for one cycle -> busy=0, done=0 and sad=0 immediately with no done pulse. A following start completes normally 17 cycles later.
